// File: rtl/motoro3_lcp_pkg.sv
// Shared definitions for the sequential line calculator: FSM encoding,
// power-percent reciprocal constants and Q15 |sin| lookup tables.
// Purely combinational helpers; no state.
package motoro3_lcp_pkg;

  typedef enum logic [2:0] {
    LCP_IDLE  = 3'd0,
    LCP_LOAD  = 3'd1,
    LCP_LUT   = 3'd2,
    LCP_MUL1  = 3'd3,
    LCP_MUL2  = 3'd4,
    LCP_CLAMP = 3'd5,
    LCP_DONE  = 3'd6
  } lcp_state_e;

  // pct * 41 >> 12 approximates pct / 100
  localparam int LCP_RECIP    = 41;
  localparam int LCP_RECIP_SH = 12;
  localparam int LCP_PCT_W    = 14;
  // sine values are Q15 (32768 == 1.0)
  localparam int LCP_SINE_SH  = 15;

  // Rounded |sin(360deg * k / steps)| * 32768 for steps = 6, 12 or 24.
  // The tables repeat every half period, so only the first half is stored.
  function automatic logic [15:0] lcp_sine_q15(input int steps, input int k);
    logic [15:0] v;
    int          j;
    v = 16'd0;
    j = k % (steps / 2);
    case (steps)
      6: begin
        case (j)
          1, 2:    v = 16'd28378;
          default: v = 16'd0;
        endcase
      end
      24: begin
        case (j)
          1:       v = 16'd8481;
          2:       v = 16'd16384;
          3:       v = 16'd23170;
          4:       v = 16'd28378;
          5:       v = 16'd31651;
          6:       v = 16'd32768;
          7:       v = 16'd31651;
          8:       v = 16'd28378;
          9:       v = 16'd23170;
          10:      v = 16'd16384;
          11:      v = 16'd8481;
          default: v = 16'd0;
        endcase
      end
      default: begin
        case (j)
          1:       v = 16'd16384;
          2:       v = 16'd28378;
          3:       v = 16'd32768;
          4:       v = 16'd28378;
          5:       v = 16'd16384;
          default: v = 16'd0;
        endcase
      end
    endcase
    return v;
  endfunction

endpackage

// File: rtl/motoro3_sine_rom.sv
// Q15 |sin| lookup ROM indexed by electrical step.
// Latency: one cycle (registered read), no reset needed on the data path.
// No backpressure: a new address may be presented every cycle.
module motoro3_sine_rom
  import motoro3_lcp_pkg::*;
#(
  parameter int STEPS  = 12,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [15:0]       dat_o
);

  logic [15:0] dat_q;

  // Registered table read
  always_ff @(posedge clk_i) begin
    dat_q <= lcp_sine_q15(STEPS, 32'(addr_i));
  end

  assign dat_o = dat_q;

endmodule

// File: rtl/motoro3_line_calc_param_seq.sv
// Sequential per-phase sine/PWM length calculator with one shared shift-add multiplier.
// Latency: done in cycle 2 + PHASES*(2*PWM_W+4) after start (86 for defaults).
// Backpressure: none; start while busy (including the done cycle) is dropped.
// Optional feature macro: MOTORO3_LCP_MINMASK_EN (suppress lengths below m3r_pwmMinMask).
module motoro3_line_calc_param_seq
  import motoro3_lcp_pkg::*;
#(
  parameter int PHASES = 3,
  parameter int STEPS  = 12,
  parameter int STEP_W = 5,
  parameter int PWM_W  = 12,
  parameter int LEN_W  = 16
) (
  input  logic                    clk,
  input  logic                    nRst,
  input  logic                    start,
  input  logic [7:0]              m3r_power_percent,
  input  logic [24:0]             m3r_stepCNT_speedSET,
  input  logic [PWM_W-1:0]        m3r_pwmLenWant,
  input  logic [PWM_W-1:0]        m3r_pwmMinMask,
  input  logic [STEP_W-1:0]       lcStep,
  output logic                    busy,
  output logic                    done,
  output logic                    stepErr,
  output logic [PHASES*LEN_W-1:0] slLen,
  output logic [PHASES*LEN_W-1:0] plLen,
  output logic [PHASES-1:0]       plPol
);

  localparam logic [2:0] ST_IDLE  = LCP_IDLE;
  localparam logic [2:0] ST_LOAD  = LCP_LOAD;
  localparam logic [2:0] ST_LUT   = LCP_LUT;
  localparam logic [2:0] ST_MUL1  = LCP_MUL1;
  localparam logic [2:0] ST_MUL2  = LCP_MUL2;
  localparam logic [2:0] ST_CLAMP = LCP_CLAMP;
  localparam logic [2:0] ST_DONE  = LCP_DONE;

  localparam int PH_W   = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam int ACC_W  = LEN_W + 16;
  localparam int CNT_W  = 5;
  localparam int PH_OFS = STEPS / PHASES;

  // control / latched-input registers
  logic [2:0]        state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [PWM_W-1:0]  p1_q, p1_d;
  logic [PWM_W-1:0]  want_q, want_d;
  logic [PWM_W-1:0]  mask_q, mask_d;
  logic [7:0]        pct_q, pct_d;
  logic              spd_zero_q, spd_zero_d;
  logic [STEP_W-1:0] step_q, step_d;

  // per-phase staging and output registers
  logic [LEN_W-1:0]  sl_stg_q [PHASES];
  logic [LEN_W-1:0]  sl_stg_d [PHASES];
  logic [LEN_W-1:0]  pl_stg_q [PHASES];
  logic [LEN_W-1:0]  pl_stg_d [PHASES];
  logic [PHASES-1:0] pol_stg_q, pol_stg_d;
  logic [LEN_W-1:0]  sl_out_q [PHASES];
  logic [LEN_W-1:0]  sl_out_d [PHASES];
  logic [LEN_W-1:0]  pl_out_q [PHASES];
  logic [LEN_W-1:0]  pl_out_d [PHASES];
  logic [PHASES-1:0] pol_out_q, pol_out_d;
  logic              err_out_q, err_out_d;

  // datapath nets
  logic                 step_err;
  logic                 force_zero;
  logic [STEP_W:0]      k_sum;
  logic [STEP_W-1:0]    k_addr;
  logic                 k_pos;
  logic [15:0]          rom_dat;
  logic [LCP_PCT_W-1:0] pct_scale;
  logic [31:0]          mul_a;
  logic [ACC_W-1:0]     mul_b;
  logic [ACC_W-1:0]     acc_next;
  logic [ACC_W-1:0]     p2;
  logic [PWM_W-1:0]     p3;
  logic [PWM_W-1:0]     pl_new;
  logic                 pol_new;
  logic                 last_phase;

  assign step_err   = ({1'b0, step_q} >= (STEP_W+1)'(STEPS));
  assign force_zero = spd_zero_q | step_err;
  assign last_phase = (phase_q == PH_W'(PHASES - 1));

  // Table index for the current phase; an out-of-range step reads entry 0
  always_comb begin
    k_sum = {1'b0, step_q} + (STEP_W+1)'(phase_q * PH_OFS);
    if (k_sum >= (STEP_W+1)'(STEPS)) begin
      k_sum = k_sum - (STEP_W+1)'(STEPS);
    end
    k_addr = step_err ? '0 : k_sum[STEP_W-1:0];
  end

  assign k_pos = (32'(k_addr) < (STEPS / 2));

  motoro3_sine_rom #(
    .STEPS  (STEPS),
    .ADDR_W (STEP_W)
  ) u_sine_rom (
    .clk_i  (clk),
    .addr_i (k_addr),
    .dat_o  (rom_dat)
  );

  // Shared shift-add: MUL1 scales sine by want, MUL2 scales p1 by pct*41.
  // The ROM address is held from LUT through CLAMP, so rom_dat stays valid.
  always_comb begin
    pct_scale = LCP_PCT_W'(32'(pct_q) * LCP_RECIP);
    if (state_q == ST_MUL1) begin
      mul_a = 32'(want_q);
      mul_b = ACC_W'(rom_dat);
    end else begin
      mul_a = 32'(pct_scale);
      mul_b = ACC_W'(p1_q);
    end
    acc_next = acc_q + (mul_a[cnt_q] ? (mul_b << cnt_q) : '0);
  end

  // Clamp to want, optional minimum-length suppression, stop/error forcing
  always_comb begin
    p2     = acc_q >> LCP_RECIP_SH;
    p3     = (p2 > ACC_W'(want_q)) ? want_q : PWM_W'(p2);
`ifdef MOTORO3_LCP_MINMASK_EN
    pl_new = (p3 < mask_q) ? '0 : p3;
`else
    pl_new = p3;
`endif
    pol_new = k_pos;
    if (force_zero) begin
      pl_new  = '0;
      pol_new = 1'b0;
    end
  end

`ifndef MOTORO3_LCP_MINMASK_EN
  // mask is latched for register-map symmetry but has no effect here
  logic unused_mask;
  assign unused_mask = ^mask_q;
`endif

  // Sequencer: load, then LUT/MUL1/MUL2/CLAMP per phase, then publish
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    p1_d       = p1_q;
    want_d     = want_q;
    mask_d     = mask_q;
    pct_d      = pct_q;
    spd_zero_d = spd_zero_q;
    step_d     = step_q;
    sl_stg_d   = sl_stg_q;
    pl_stg_d   = pl_stg_q;
    pol_stg_d  = pol_stg_q;
    sl_out_d   = sl_out_q;
    pl_out_d   = pl_out_q;
    pol_out_d  = pol_out_q;
    err_out_d  = err_out_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        want_d     = m3r_pwmLenWant;
        mask_d     = m3r_pwmMinMask;
        pct_d      = m3r_power_percent;
        spd_zero_d = (m3r_stepCNT_speedSET == '0);
        step_d     = lcStep;
        phase_d    = '0;
        state_d    = ST_LUT;
      end
      ST_LUT: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = ST_MUL1;
      end
      ST_MUL1: begin
        acc_d = acc_next;
        if (cnt_q == CNT_W'(PWM_W - 1)) begin
          p1_d    = PWM_W'(acc_next >> LCP_SINE_SH);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_MUL2;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_MUL2: begin
        acc_d = acc_next;
        if (cnt_q == CNT_W'(PWM_W + 1)) begin
          state_d = ST_CLAMP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CLAMP: begin
        sl_stg_d[phase_q]  = LEN_W'(rom_dat);
        pl_stg_d[phase_q]  = LEN_W'(pl_new);
        pol_stg_d[phase_q] = pol_new;
        if (last_phase) begin
          // outputs load on entry to DONE so they change together with done
          sl_out_d  = sl_stg_d;
          pl_out_d  = pl_stg_d;
          pol_out_d = pol_stg_d;
          err_out_d = step_err;
          state_d   = ST_DONE;
        end else begin
          phase_d = phase_q + 1'b1;
          state_d = ST_LUT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      p1_q       <= '0;
      want_q     <= '0;
      mask_q     <= '0;
      pct_q      <= '0;
      spd_zero_q <= 1'b0;
      step_q     <= '0;
      sl_stg_q   <= '{default: '0};
      pl_stg_q   <= '{default: '0};
      pol_stg_q  <= '0;
      sl_out_q   <= '{default: '0};
      pl_out_q   <= '{default: '0};
      pol_out_q  <= '0;
      err_out_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      p1_q       <= p1_d;
      want_q     <= want_d;
      mask_q     <= mask_d;
      pct_q      <= pct_d;
      spd_zero_q <= spd_zero_d;
      step_q     <= step_d;
      sl_stg_q   <= sl_stg_d;
      pl_stg_q   <= pl_stg_d;
      pol_stg_q  <= pol_stg_d;
      sl_out_q   <= sl_out_d;
      pl_out_q   <= pl_out_d;
      pol_out_q  <= pol_out_d;
      err_out_q  <= err_out_d;
    end
  end

  for (genvar i = 0; i < PHASES; i++) begin : g_out
    assign slLen[i*LEN_W +: LEN_W] = sl_out_q[i];
    assign plLen[i*LEN_W +: LEN_W] = pl_out_q[i];
  end

  assign plPol   = pol_out_q;
  assign stepErr = err_out_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_motoro3_line_calc_param_seq.sv
// Directed + randomized bench for the sequential line calculator.
// Results are compared against a plain-arithmetic reference model.
// Every wait on done is bounded by a cycle budget.
module tb_motoro3_line_calc_param_seq;

  logic        clk;
  logic        nRst;
  logic        start;
  logic [7:0]  m3r_power_percent;
  logic [24:0] m3r_stepCNT_speedSET;
  logic [11:0] m3r_pwmLenWant;
  logic [11:0] m3r_pwmMinMask;
  logic [4:0]  lcStep;
  logic        busy;
  logic        done;
  logic        stepErr;
  logic [47:0] slLen;
  logic [47:0] plLen;
  logic [2:0]  plPol;

  int tests = 0;
  int fails = 0;
  int sine12 [12] = '{0, 16384, 28378, 32768, 28378, 16384,
                      0, 16384, 28378, 32768, 28378, 16384};

  motoro3_line_calc_param_seq dut (
    .clk                  (clk),
    .nRst                 (nRst),
    .start                (start),
    .m3r_power_percent    (m3r_power_percent),
    .m3r_stepCNT_speedSET (m3r_stepCNT_speedSET),
    .m3r_pwmLenWant       (m3r_pwmLenWant),
    .m3r_pwmMinMask       (m3r_pwmMinMask),
    .lcStep               (lcStep),
    .busy                 (busy),
    .done                 (done),
    .stepErr              (stepErr),
    .slLen                (slLen),
    .plLen                (plLen),
    .plPol                (plPol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: per phase k, sine lookup, scale, clamp, mask, force
  task automatic model(input int want, input int pct, input int spd, input int mask,
                       input int step, output logic [47:0] esl, output logic [47:0] epl,
                       output logic [2:0] epol, output logic eerr);
    eerr = (step >= 12);
    esl  = '0;
    epl  = '0;
    epol = '0;
    for (int p = 0; p < 3; p++) begin
      int k, s, p1, p2, p3;
      bit pos;
      k   = eerr ? 0 : (step + p * 4) % 12;
      s   = sine12[k];
      pos = (k < 6);
      p1  = (want * s) / 32768;
      p2  = (p1 * pct * 41) / 4096;
      p3  = (p2 < want) ? p2 : want;
`ifdef MOTORO3_LCP_MINMASK_EN
      if (p3 < mask) p3 = 0;
`else
      if (mask < 0) p3 = 0;
`endif
      if (spd == 0 || eerr) begin
        p3  = 0;
        pos = 1'b0;
      end
      esl[p*16 +: 16] = s[15:0];
      epl[p*16 +: 16] = p3[15:0];
      epol[p]         = pos;
    end
  endtask

  // Start one calculation; optional second start and optional reset mid-run.
  // Returns the cycle (relative to the start cycle) in which done was seen, or -1.
  task automatic go(input int want, input int pct, input int spd, input int mask,
                    input int step, input int mid_start, input int rst_at, output int dc);
    logic [47:0] pl_prev, sl_prev;
    int cyc;
    bit fin;
    pl_prev = plLen;
    sl_prev = slLen;
    m3r_pwmLenWant       = want[11:0];
    m3r_power_percent    = pct[7:0];
    m3r_stepCNT_speedSET = spd[24:0];
    m3r_pwmMinMask       = mask[11:0];
    lcStep               = step[4:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    dc  = -1;
    fin = 1'b0;
    check("busy_after_start", busy, 1);
    while (!fin && cyc < 300) begin
      if (cyc == 2) begin
        // inputs are latched by now; scramble them
        m3r_pwmLenWant       = 12'($urandom);
        m3r_power_percent    = 8'($urandom);
        m3r_stepCNT_speedSET = 25'($urandom);
        m3r_pwmMinMask       = 12'($urandom);
        lcStep               = 5'($urandom);
      end
      if (cyc == mid_start) start = 1'b1;
      if (cyc == rst_at) nRst = 1'b0;
      tick();
      cyc++;
      start = 1'b0;
      if (rst_at >= 0 && cyc == rst_at + 1) begin
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_plLen", plLen, 0);
        check("rst_slLen", slLen, 0);
        check("rst_plPol", plPol, 0);
        nRst = 1'b1;
        fin  = 1'b1;
      end else begin
        if (cyc == 40) begin
          check("hold_plLen", plLen, pl_prev);
          check("hold_slLen", slLen, sl_prev);
        end
        if (done) begin
          dc  = cyc;
          fin = 1'b1;
        end
      end
    end
  endtask

  task automatic run_chk(input string tag, input int want, input int pct, input int spd,
                         input int mask, input int step, input int mid, input bit hold_start);
    logic [47:0] esl, epl;
    logic [2:0]  epol;
    logic        eerr;
    int          dc;
    model(want, pct, spd, mask, step, esl, epl, epol, eerr);
    go(want, pct, spd, mask, step, mid, -1, dc);
    check({tag, "_done_cyc"}, dc, 86);
    check({tag, "_busy_in_done"}, busy, 1);
    check({tag, "_slLen"}, slLen, esl);
    check({tag, "_plLen"}, plLen, epl);
    check({tag, "_plPol"}, plPol, epol);
    check({tag, "_stepErr"}, stepErr, eerr);
    if (hold_start) start = 1'b1;
    tick();
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    int dc;
    nRst = 1'b0;
    start = 1'b0;
    m3r_power_percent    = '0;
    m3r_stepCNT_speedSET = '0;
    m3r_pwmLenWant       = '0;
    m3r_pwmMinMask       = '0;
    lcStep               = '0;
    repeat (3) tick();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_stepErr", stepErr, 0);
    check("reset_slLen", slLen, 0);
    check("reset_plLen", plLen, 0);
    check("reset_plPol", plPol, 0);
    nRst = 1'b1;
    tick();

    run_chk("basic", 1000, 100, 1, 0, 0, -1, 1'b0);
    check("basic_sl_const", slLen, {16'd28378, 16'd28378, 16'd0});
    check("basic_pl_const", plLen, {16'd866, 16'd866, 16'd0});

    run_chk("pct255", 1000, 255, 1, 0, 3, -1, 1'b0);
    check("pct255_clamp", plLen[15:0], 1000);

    run_chk("mask", 1000, 10, 1, 120, 3, -1, 1'b0);
`ifdef MOTORO3_LCP_MINMASK_EN
    check("mask_ph0", plLen[15:0], 0);
`else
    check("mask_ph0", plLen[15:0], 100);
`endif

    run_chk("spd0", 1000, 100, 0, 0, 3, -1, 1'b0);
    run_chk("step12", 1000, 100, 1, 0, 12, -1, 1'b0);

    // second start at cycle 40 is dropped; start held through the done cycle
    // and the next one: only the latter is accepted (done at 173 overall)
    run_chk("midstart", 800, 77, 5, 0, 7, 40, 1'b1);
    run_chk("b2b", 3000, 150, 9, 50, 10, -1, 1'b0);

    // reset aborts a calculation at cycle 50, then a normal run follows
    go(1234, 90, 3, 0, 5, -1, 50, dc);
    run_chk("after_rst", 2047, 200, 2, 0, 5, -1, 1'b0);

    for (int i = 0; i < 10; i++) begin
      int w, pc, sp, mk, st;
      w  = $urandom_range(0, 4095);
      pc = $urandom_range(1, 255);
      sp = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 100000);
      mk = $urandom_range(0, 600);
      st = $urandom_range(0, 15);
      run_chk("rand", w, pc, sp, mk, st, -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
